// File: rtl/screenchar_write_arbiter.sv
// Round-robin burst arbiter for the single write port of the screen character memory.
// Producers (velocity/angle digit writer, terminal printer, targets printer, ...) stream
// (char_index, char_data) beats over a valid/ready handshake. A whole burst is granted to
// one producer at a time, and every accepted beat is replayed on the memory write port
// one cycle later from registers.
//
// Ports:
//   clock          rising-edge system clock
//   resetn         asynchronous active-low reset
//   req_valid      per-requester beat valid
//   req_last       per-requester final beat of burst (qualified by valid)
//   req_addr       packed char indices, requester i at [i*ADDR_W +: ADDR_W]
//   req_data       packed char codes, same packing
//   req_ready      one-hot ready to the current owner; beat accepted on valid & ready
//   mem_wren       memory write enable (registered)
//   mem_wraddress  memory write address (registered)
//   mem_data       memory write data (registered)
//   busy           a burst grant is active
//   grant_id       index of the current / last owner
module screenchar_write_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       mem_wren,
  output logic [ADDR_W-1:0]          mem_wraddress,
  output logic [DATA_W-1:0]          mem_data,
  output logic                       busy,
  output logic [2:0]                 grant_id
);

  localparam logic [7:0] MaxBeats  = 8'(MAX_BURST);
  localparam logic [7:0] IdleLimit = 8'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBurst, StRelease} state_e;

  state_e               state_q;
  logic [2:0]           rr_ptr_q;
  logic [2:0]           owner_q;
  logic [7:0]           beat_cnt_q;
  logic [7:0]           idle_cnt_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 wren_q;
  logic [ADDR_W-1:0]    wraddr_q;
  logic [DATA_W-1:0]    wrdata_q;
  logic                 busy_q;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  logic                 found;
  logic [2:0]           pick;
  logic [NUM_REQ-1:0]   pick_onehot;
  int unsigned          idx;

  always_comb begin
    found       = 1'b0;
    pick        = 3'd0;
    idx         = 0;
    pick_onehot = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == idx) && req_valid[i]) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = (pick == 3'(i));
    end
  end

  // Owner's request signals.
  logic              own_valid;
  logic              own_last;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_addr  = req_addr[i*ADDR_W +: ADDR_W];
        own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  logic [7:0] beat_cnt_inc;
  logic [7:0] idle_cnt_inc;
  logic [2:0] owner_next;

  assign beat_cnt_inc = beat_cnt_q + 8'd1;
  assign idle_cnt_inc = idle_cnt_q + 8'd1;
  assign owner_next   = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 3'd0;
      owner_q    <= 3'd0;
      beat_cnt_q <= 8'd0;
      idle_cnt_q <= 8'd0;
      ready_q    <= '0;
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      // A write is issued only in the cycle right after an accepted beat.
      wren_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            owner_q <= pick;
            busy_q  <= 1'b1;
            ready_q <= pick_onehot;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (own_valid) begin
            wren_q     <= 1'b1;
            wraddr_q   <= own_addr;
            wrdata_q   <= own_data;
            beat_cnt_q <= beat_cnt_inc;
            idle_cnt_q <= 8'd0;
            // Ready drops on the accepting edge so no beat past the release is taken.
            if (own_last || (beat_cnt_inc == MaxBeats)) begin
              ready_q <= '0;
              state_q <= StRelease;
            end
          end else begin
            idle_cnt_q <= idle_cnt_inc;
            if (idle_cnt_inc == IdleLimit) begin
              ready_q <= '0;
              state_q <= StRelease;
            end
          end
        end
        StRelease: begin
          busy_q     <= 1'b0;
          rr_ptr_q   <= owner_next;
          beat_cnt_q <= 8'd0;
          idle_cnt_q <= 8'd0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign mem_wren      = wren_q;
  assign mem_wraddress = wraddr_q;
  assign mem_data      = wrdata_q;
  assign busy          = busy_q;
  assign grant_id      = owner_q;

endmodule

// File: tb/tb_screenchar_write_arbiter.sv
// Directed self-checking bench for screenchar_write_arbiter (3 requesters, 8-bit fields,
// MAX_BURST=64, IDLE_TIMEOUT=16).
module tb_screenchar_write_arbiter;

  localparam int NR = 3;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*8-1:0]   req_addr;
  logic [NR*8-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              mem_wren;
  logic [7:0]        mem_wraddress;
  logic [7:0]        mem_data;
  logic              busy;
  logic [2:0]        grant_id;

  logic       v[NR] = '{default: 1'b0};
  logic       l[NR] = '{default: 1'b0};
  logic [7:0] a[NR] = '{default: 8'h00};
  logic [7:0] d[NR] = '{default: 8'h00};

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = v[i];
      req_last[i]        = l[i];
      req_addr[i*8 +: 8] = a[i];
      req_data[i*8 +: 8] = d[i];
    end
  end

  screenchar_write_arbiter #(
    .NUM_REQ      (NR),
    .ADDR_W       (8),
    .DATA_W       (8),
    .MAX_BURST    (64),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .mem_wren      (mem_wren),
    .mem_wraddress (mem_wraddress),
    .mem_data      (mem_data),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Write log and handshake monitor, sampled on the falling edge.
  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  log_q[$];
  int   cyc = 0;
  int   bad = 0;
  logic acc_prev = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (mem_wren === 1'b1) log_q.push_back('{cyc, mem_wraddress, mem_data});
    if (resetn && (mem_wren !== acc_prev)) bad++;
    if ($countones(req_ready) > 1) bad++;
    acc_prev = resetn && (|(req_valid & req_ready));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < NR; i++) begin
      v[i] = 1'b0;
      l[i] = 1'b0;
    end
    tick();
    tick();
    @(negedge clock);
    resetn = 1'b1;
    tick();
    log_q.delete();
  endtask

  // Streams n beats from requester r, waiting (bounded) for each acceptance.
  task automatic send(input int r, input int n, input logic [7:0] a0, input logic [7:0] d0,
                      input bit with_last);
    bit ok;
    int waited;
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      v[r] = 1'b1;
      a[r] = a0 + 8'(i);
      d[r] = d0 + 8'(i);
      l[r] = with_last && (i == n - 1);
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 300) begin
        @(negedge clock);
        ok = req_ready[r];
        tick();
        waited++;
      end
    end
    v[r] = 1'b0;
    l[r] = 1'b0;
    check($sformatf("send_done_r%0d", r), {31'd0, ok}, 32'd1);
  endtask

  int mism;
  int waited6;
  bit ok6;

  initial begin
    // ---- Reset state, then requester 1 three-beat burst ----
    do_reset();
    check("rst_ready", {29'd0, req_ready}, 32'h0);
    check("rst_wren", {31'd0, mem_wren}, 32'h0);
    check("rst_addr", {24'd0, mem_wraddress}, 32'h0);
    check("rst_data", {24'd0, mem_data}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_grant", {29'd0, grant_id}, 32'h0);

    v[1] = 1'b1; a[1] = 8'h59; d[1] = "1"; l[1] = 1'b0;
    tick();
    check("t1_ready", {29'd0, req_ready}, 32'h2);
    check("t1_busy", {31'd0, busy}, 32'h1);
    check("t1_wren0", {31'd0, mem_wren}, 32'h0);
    tick();
    check("t1_w1", {23'd0, mem_wren, mem_wraddress, mem_data}, {23'd0, 1'b1, 8'h59, 8'h31});
    a[1] = 8'h5A; d[1] = "2";
    tick();
    check("t1_w2", {23'd0, mem_wren, mem_wraddress, mem_data}, {23'd0, 1'b1, 8'h5A, 8'h32});
    a[1] = 8'h5B; d[1] = "3"; l[1] = 1'b1;
    tick();
    check("t1_w3", {23'd0, mem_wren, mem_wraddress, mem_data}, {23'd0, 1'b1, 8'h5B, 8'h33});
    check("t1_ready_drop", {29'd0, req_ready}, 32'h0);
    v[1] = 1'b0; l[1] = 1'b0;
    tick();
    check("t1_wren_end", {31'd0, mem_wren}, 32'h0);
    check("t1_busy_end", {31'd0, busy}, 32'h0);
    check("t1_grant_end", {29'd0, grant_id}, 32'h1);

    // ---- All three requesters at once, 2-beat bursts ----
    do_reset();
    fork
      send(0, 2, 8'h20, 8'hA0, 1'b1);
      send(1, 2, 8'h30, 8'hB0, 1'b1);
      send(2, 2, 8'h40, 8'hC0, 1'b1);
    join
    tick();
    tick();
    check("t2_count", 32'(log_q.size()), 32'd6);
    mism = 0;
    for (int i = 0; i < 6; i++) begin
      if (i >= log_q.size() || log_q[i].addr !== 8'h20 + 8'(16 * (i / 2)) + 8'(i % 2))
        mism++;
    end
    check("t2_order", 32'(mism), 32'd0);
    if (log_q.size() == 6) begin
      check("t2_back2back", 32'(log_q[1].cyc - log_q[0].cyc), 32'd1);
      check("t2_gap01", 32'(log_q[2].cyc - log_q[1].cyc), 32'd3);
      check("t2_gap12", 32'(log_q[4].cyc - log_q[3].cyc), 32'd3);
    end

    // ---- 100-beat stream from 0 with requester 2 waiting ----
    do_reset();
    fork
      send(0, 100, 8'h00, 8'h80, 1'b1);
      send(2, 2, 8'hC0, 8'h40, 1'b1);
    join
    tick();
    tick();
    check("t3_count", 32'(log_q.size()), 32'd102);
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= log_q.size() || log_q[i].addr !== 8'(i) || log_q[i].data !== 8'h80 + 8'(i))
        mism++;
    end
    check("t3_first64", 32'(mism), 32'd0);
    mism = 0;
    for (int i = 0; i < 2; i++) begin
      if (64 + i >= log_q.size() || log_q[64 + i].addr !== 8'hC0 + 8'(i)) mism++;
    end
    check("t3_req2", 32'(mism), 32'd0);
    mism = 0;
    for (int i = 0; i < 36; i++) begin
      if (66 + i >= log_q.size() || log_q[66 + i].addr !== 8'(64 + i)) mism++;
    end
    check("t3_rest36", 32'(mism), 32'd0);

    // ---- Idle timeout: owner stops after 2 beats without last ----
    do_reset();
    fork
      send(0, 2, 8'h50, 8'h10, 1'b0);
      send(1, 1, 8'h60, 8'h11, 1'b1);
    join
    tick();
    tick();
    check("t4_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check("t4_addr", {24'd0, log_q[2].addr}, 32'h60);
      check("t4_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd19);
    end
    check("t4_grant", {29'd0, grant_id}, 32'h1);

    // ---- Non-owner changes held data while waiting ----
    do_reset();
    fork
      send(0, 3, 8'h10, 8'h90, 1'b1);
      begin
        v[1] = 1'b1; a[1] = 8'h70; d[1] = 8'h11; l[1] = 1'b1;
        tick();
        tick();
        check("t6_nonowner_ready", {31'd0, req_ready[1]}, 32'h0);
        a[1] = 8'h71; d[1] = 8'h22;
        ok6 = 1'b0;
        waited6 = 0;
        while (!ok6 && waited6 < 50) begin
          @(negedge clock);
          ok6 = req_ready[1];
          tick();
          waited6++;
        end
        v[1] = 1'b0; l[1] = 1'b0;
        check("t6_granted", {31'd0, ok6}, 32'h1);
      end
    join
    tick();
    tick();
    check("t6_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      check("t6_held", {16'd0, log_q[3].addr, log_q[3].data}, 32'h7122);
    end
    mism = 0;
    foreach (log_q[i]) if (log_q[i].data === 8'h11) mism++;
    check("t6_stale", 32'(mism), 32'd0);

    // ---- Reset mid-burst, then requester 0 has priority again ----
    do_reset();
    send(1, 1, 8'h05, 8'h55, 1'b1);
    tick();
    tick();
    v[0] = 1'b1; a[0] = 8'h10; d[0] = 8'hA0; l[0] = 1'b0;
    tick();
    check("t5_grant0", {29'd0, grant_id}, 32'h0);
    tick();
    a[0] = 8'h11; d[0] = 8'hA1;
    #3;
    resetn = 1'b0;
    #1;
    check("t5_async", {18'd0, req_ready, mem_wren, mem_wraddress, mem_data, busy, grant_id},
          32'h0);
    v[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    log_q.delete();
    v[0] = 1'b1; a[0] = 8'h12; d[0] = 8'hA2; l[0] = 1'b1;
    v[2] = 1'b1; a[2] = 8'hC5; d[2] = 8'hB5; l[2] = 1'b1;
    tick();
    check("t5_pri_grant", {29'd0, grant_id}, 32'h0);
    check("t5_pri_ready", {29'd0, req_ready}, 32'h1);
    tick();
    v[0] = 1'b0; l[0] = 1'b0;
    tick();
    tick();
    check("t5_next_grant", {29'd0, grant_id}, 32'h2);
    tick();
    v[2] = 1'b0; l[2] = 1'b0;
    tick();
    tick();
    check("t5_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("t5_first", {24'd0, log_q[0].addr}, 32'h12);
      check("t5_second", {24'd0, log_q[1].addr}, 32'hC5);
    end

    check("wren_protocol", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screenchar_write_arbiter.md
Name: screenchar_write_arbiter

Overview:
- Shares the single write port of the screen character memory between several character producers: velocity/angle digit writer, terminal printer, targets printer.
- Each producer streams (char_index, char_data) beats as a burst.
- Grants whole bursts in round-robin order and drives registered write signals to the memory.
- Replaces free-running per-source sequencing with an explicit valid/ready handshake.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 8, character index width.
- DATA_W, 8, character code width.
- MAX_BURST, 64, maximum beats per grant before forced release (1..255).
- IDLE_TIMEOUT, 16, consecutive owner-idle cycles before forced release (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester final beat of burst, qualified by valid.
- req_addr  in  NUM_REQ*ADDR_W  packed char indices; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed char codes; same packing.
- req_ready  out  NUM_REQ  one-hot; beat accepted when valid & ready.
- mem_wren  out  1  memory write enable.
- mem_wraddress  out  ADDR_W  memory write address.
- mem_data  out  DATA_W  memory write data.
- busy  out  1  a burst grant is active.
- grant_id  out  3  index of current/last owner.

Behaviour:
- Reset (async assert, sync release):
  - req_ready=0, mem_wren=0, mem_wraddress=0, mem_data=0, busy=0, grant_id=0.
  - State=IDLE, rr_ptr=0, beat_cnt=0, idle_cnt=0.
  - Reset mid-burst abandons the burst; beats not yet written are lost, and requesters restart after reset.
- States:
  - IDLE:
    - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
    - If any bit is set, take the first hit as owner: grant_id<=owner, busy<=1, req_ready<=onehot(owner), go BURST.
    - If no bit is set, stay in IDLE.
  - BURST:
    - req_ready stays onehot(owner).
    - Owner valid=1: the beat is accepted this cycle. Next cycle mem_wren=1 with mem_wraddress/mem_data equal to the accepted beat. beat_cnt++, idle_cnt<=0.
    - Owner valid=0: mem_wren=0 next cycle, idle_cnt++.
    - Release condition: accepted beat has req_last=1, OR beat_cnt reaches MAX_BURST on this beat, OR idle_cnt reaches IDLE_TIMEOUT.
    - On release: req_ready<=0 on the following edge, go RELEASE.
  - RELEASE:
    - One cycle: busy<=0, rr_ptr<=(owner+1) mod NUM_REQ, counters cleared.
    - mem_wren reflects the final beat if one was accepted. Then go IDLE.
- Latency:
  - Valid seen in IDLE at edge t; req_ready high from t+1.
  - First beat accepted at t+1; written (mem_wren) at t+2.
  - Throughput is one beat per clock within a burst.
  - Minimum gap between bursts is 2 cycles (RELEASE + IDLE).
- Handshake rules:
  - Non-owners always see ready=0 and must hold valid/addr/data stable until granted.
  - The arbiter never drops an accepted beat.
- mem_wren is 0 in every cycle not immediately following an accepted beat.
- The memory samples on the opposite clock edge, so all write outputs are registered and stable a full cycle.
- Simultaneous requests resolve by round-robin from rr_ptr. After reset requester 0 has priority, and no requester wins twice while another waits.
- A single-beat burst (last=1 on first beat) is legal.
- A MAX_BURST forced release leaves the remainder pending. The requester keeps valid high and is re-granted on its next round-robin turn, continuing where it stopped.
- beat_cnt and idle_cnt are 8 bits and never wrap past their limits, because release occurs at equality.

Test Plan:
- Reset, then requester 1 sends 3 beats (addr 0x59,0x5A,0x5B; data '1','2','3'; last on the third) -> ready[1] one cycle after valid; mem_wren pulses 3 consecutive cycles with matching addr/data; busy drops; grant_id=1.
- All three requesters valid simultaneously, each a 2-beat burst -> grants in order 0,1,2; each burst separated by exactly 2 idle write cycles; no interleaving of addresses.
- Requester 0 streams 100 beats with MAX_BURST=64 while requester 2 waits -> 64 writes from 0, then requester 2's burst, then remaining 36 from 0.
- Owner deasserts valid for 16 cycles mid-burst with no last -> forced release after the 16th idle cycle; next waiting requester granted; no spurious mem_wren.
- resetn pulled low during beat 2 of a 5-beat burst -> all outputs 0 immediately (asynchronously); after release requester 0 is granted first.
- Non-owner changes data while ready=0 -> no write occurs for it until granted; then its current held data is written.
